// File: rtl/intra_4x4_mode_ctx_if.sv
// Block-mode input and coded-syntax output channels of intra_4x4_mode_ctx.
// Both channels transfer exactly on a clock edge where valid & ready are high;
// a producer holds its payload steady while valid is high and ready is low.
interface intra_4x4_mode_ctx_if;
    logic       blk_valid;
    logic       blk_ready;
    logic [3:0] blk_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_blk;
    logic [3:0] out_pred;
    logic       out_prev_flag;
    logic [2:0] out_rem;

    modport master (
        output blk_valid, blk_mode, out_ready,
        input  blk_ready, out_valid, out_blk, out_pred, out_prev_flag, out_rem
    );

    modport slave (
        input  blk_valid, blk_mode, out_ready,
        output blk_ready, out_valid, out_blk, out_pred, out_prev_flag, out_rem
    );
endinterface

// File: rtl/intra_4x4_mode_ctx.sv
// Intra4x4 predicted-mode context: owns top line buffer, left column and MB mode matrix.
// Optional slice-aware availability is enabled with `define INTRA_MODE_SLICE_EN.
module intra_4x4_mode_ctx #(
    parameter int PIC_W_MB = 120,
    parameter int MBX_W    = 7,
    parameter int MBY_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mb_start,
    input  logic [MBX_W-1:0] mb_x,
    input  logic [MBY_W-1:0] mb_y,
    input  logic             mb_i4x4,
`ifdef INTRA_MODE_SLICE_EN
    input  logic             slice_start,
`endif
    intra_4x4_mode_ctx_if.slave bus,
    output logic             mb_done,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

    state_t             state;
    logic [3:0]         blk_cnt;
    logic [MBX_W-1:0]   cur_x;
    logic [MBY_W-1:0]   cur_y;
    logic               cur_i4x4;
    logic [3:0]         mat      [16];
    logic [3:0]         top_row  [4];
    logic [3:0]         left_col [4];
    logic [15:0]        linebuf  [PIC_W_MB];

    logic       accept, left_ok, top_ok, a_ok, b_ok, flag;
    logic [1:0] bx, by;
    logic [3:0] a_mode, b_mode, pred, mode_m1;
    logic [2:0] rem;

    function automatic logic [3:0] zidx(input logic [1:0] x, input logic [1:0] y);
        return {y[1], x[1], y[0], x[0]};
    endfunction

`ifdef INTRA_MODE_SLICE_EN
    logic [PIC_W_MB-1:0] top_avail;
    logic                left_avail;
    assign left_ok = (cur_x != '0) && left_avail;
    assign top_ok  = (cur_y != '0) && top_avail[cur_x];
`else
    assign left_ok = (cur_x != '0);
    assign top_ok  = (cur_y != '0);
`endif

    assign bus.blk_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign accept        = bus.blk_valid && bus.blk_ready;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;
    assign bx            = {blk_cnt[2], blk_cnt[0]};
    assign by            = {blk_cnt[3], blk_cnt[1]};

    // Neighbours inside the MB come from the matrix, edge neighbours from context.
    always_comb begin
        a_mode = left_col[by];
        a_ok   = left_ok;
        if (bx != 2'd0) begin
            a_mode = mat[zidx(bx - 2'd1, by)];
            a_ok   = 1'b1;
        end
        b_mode = top_row[bx];
        b_ok   = top_ok;
        if (by != 2'd0) begin
            b_mode = mat[zidx(bx, by - 2'd1)];
            b_ok   = 1'b1;
        end
        pred = 4'd2;
        if (a_ok && b_ok) pred = (a_mode < b_mode) ? a_mode : b_mode;
        flag    = (bus.blk_mode == pred);
        mode_m1 = bus.blk_mode - 4'd1;
        rem     = 3'd0;
        if (!flag) rem = (bus.blk_mode < pred) ? bus.blk_mode[2:0] : mode_m1[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            blk_cnt           <= 4'd0;
            cur_x             <= '0;
            cur_y             <= '0;
            cur_i4x4          <= 1'b0;
            mb_done           <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.out_blk       <= 4'd0;
            bus.out_pred      <= 4'd0;
            bus.out_prev_flag <= 1'b0;
            bus.out_rem       <= 3'd0;
`ifdef INTRA_MODE_SLICE_EN
            top_avail         <= '0;
            left_avail        <= 1'b0;
`endif
        end else begin
            mb_done <= 1'b0;
            if (accept) begin
                bus.out_valid     <= 1'b1;
                bus.out_blk       <= blk_cnt;
                bus.out_pred      <= pred;
                bus.out_prev_flag <= flag;
                bus.out_rem       <= rem;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                IDLE: if (mb_start) begin
                    cur_x    <= mb_x;
                    cur_y    <= mb_y;
                    cur_i4x4 <= mb_i4x4;
                    blk_cnt  <= 4'd0;
                    mb_done  <= !mb_i4x4;
                    state    <= mb_i4x4 ? RUN : COMMIT;
`ifdef INTRA_MODE_SLICE_EN
                    if (slice_start) begin
                        top_avail  <= '0;
                        left_avail <= 1'b0;
                    end
`endif
                end
                RUN: if (accept) begin
                    blk_cnt <= blk_cnt + 4'd1;
                    if (blk_cnt == 4'd15) begin
                        state   <= COMMIT;
                        mb_done <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
`ifdef INTRA_MODE_SLICE_EN
                    top_avail[cur_x] <= 1'b1;
                    left_avail       <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Context storage is left unreset; an aborted MB never reaches COMMIT.
    always_ff @(posedge clk) begin
        if (state == IDLE && mb_start) begin
            for (int i = 0; i < 4; i++) top_row[i] <= linebuf[mb_x][4*i +: 4];
        end
        if (accept) mat[blk_cnt] <= bus.blk_mode;
        if (state == COMMIT) begin
            if (cur_i4x4) begin
                linebuf[cur_x] <= {mat[15], mat[14], mat[11], mat[10]};
                left_col[0]    <= mat[5];
                left_col[1]    <= mat[7];
                left_col[2]    <= mat[13];
                left_col[3]    <= mat[15];
            end else begin
                linebuf[cur_x] <= {4{4'd2}};
                for (int i = 0; i < 4; i++) left_col[i] <= 4'd2;
            end
        end
    end
endmodule

// File: tb/tb_intra_4x4_mode_ctx.sv
// Directed bench for intra_4x4_mode_ctx: picture-context model, scoreboard and literal pins.
module tb_intra_4x4_mode_ctx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mb_start = 1'b0;
    logic [6:0] mb_x = '0;
    logic [6:0] mb_y = '0;
    logic       mb_i4x4 = 1'b0;
`ifdef INTRA_MODE_SLICE_EN
    logic       slice_start = 1'b0;
`endif
    logic       mb_done, busy;
    logic [1:0] dbg_state;

    intra_4x4_mode_ctx_if bus();

    intra_4x4_mode_ctx dut (
        .clk(clk), .rst_n(rst_n), .mb_start(mb_start), .mb_x(mb_x), .mb_y(mb_y),
        .mb_i4x4(mb_i4x4),
`ifdef INTRA_MODE_SLICE_EN
        .slice_start(slice_start),
`endif
        .bus(bus), .mb_done(mb_done), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model context: bottom row per MB column, right column of last committed MB.
    int   top_mem [0:127][0:3];
    int   left_mem[0:3];
    bit   top_av  [0:127];
    bit   left_av = 1'b0;
    int   cm[0:3][0:3];
    int   m_x, m_y;
    int   res_pred[16], res_flag[16], res_rem[16];
    logic [11:0] exp_q[$];
    longint acc_t;
    logic [11:0] held;
    bit   hold_chk = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit left_ok_m();
`ifdef INTRA_MODE_SLICE_EN
        return m_x > 0 && left_av;
`else
        return m_x > 0;
`endif
    endfunction

    function automatic bit top_ok_m();
`ifdef INTRA_MODE_SLICE_EN
        return m_y > 0 && top_av[m_x];
`else
        return m_y > 0;
`endif
    endfunction

    function automatic logic [11:0] model_blk(input int b, input int mode);
        int x, y, a, t, pred, flag, rem;
        x = ((b / 4) % 2) * 2 + (b % 2);
        y = (b / 8) * 2 + ((b / 2) % 2);
        a = (x > 0) ? cm[x-1][y] : (left_ok_m() ? left_mem[y] : -1);
        t = (y > 0) ? cm[x][y-1] : (top_ok_m() ? top_mem[m_x][x] : -1);
        pred = (a < 0 || t < 0) ? 2 : ((a < t) ? a : t);
        flag = (mode == pred) ? 1 : 0;
        rem  = flag ? 0 : (((mode < pred) ? mode : mode - 1) % 8);
        return {4'(b), 4'(pred), 1'(flag), 3'(rem)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk)
                chk("out_hold", int'({bus.out_blk, bus.out_pred, bus.out_prev_flag, bus.out_rem}), int'(held));
            if (bus.out_valid && bus.out_ready) begin
                hold_chk = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    chk("out_blk", int'(bus.out_blk), int'(e[11:8]));
                    chk("out_pred", int'(bus.out_pred), int'(e[7:4]));
                    chk("out_prev_flag", int'(bus.out_prev_flag), int'(e[3]));
                    chk("out_rem", int'(bus.out_rem), int'(e[2:0]));
                    res_pred[bus.out_blk] = int'(bus.out_pred);
                    res_flag[bus.out_blk] = int'(bus.out_prev_flag);
                    res_rem[bus.out_blk]  = int'(bus.out_rem);
                end
            end else if (bus.out_valid) begin
                hold_chk = 1'b1;
                held = {bus.out_blk, bus.out_pred, bus.out_prev_flag, bus.out_rem};
            end else begin
                hold_chk = 1'b0;
            end
        end
    end

    task automatic start_mb(input int x, input int y, input bit i4, input bit sl);
        int w = 0;
        do begin @(negedge clk); w++; end while (busy && w < 100);
        if (busy) chk("idle_timeout", 1, 0);
        @(posedge clk); #1;
        mb_start = 1'b1; mb_x = 7'(x); mb_y = 7'(y); mb_i4x4 = i4;
`ifdef INTRA_MODE_SLICE_EN
        slice_start = sl;
`endif
        if (sl) begin
            left_av = 1'b0;
            for (int i = 0; i < 128; i++) top_av[i] = 1'b0;
        end
        m_x = x; m_y = y;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) cm[i][j] = -1;
        @(posedge clk); #1;
        mb_start = 1'b0;
    endtask

    task automatic send_blk(input int b, input int mode);
        int w = 0;
        bus.blk_valid = 1'b1;
        bus.blk_mode  = 4'(mode);
        do begin @(negedge clk); w++; end while (!bus.blk_ready && w < 100);
        if (!bus.blk_ready) begin
            chk("blk_ready_timeout", 0, 1);
            bus.blk_valid = 1'b0;
            return;
        end
        exp_q.push_back(model_blk(b, mode));
        cm[((b / 4) % 2) * 2 + (b % 2)][(b / 8) * 2 + ((b / 2) % 2)] = mode;
        @(posedge clk);
        acc_t = $time;
        #1 bus.blk_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 50) begin @(negedge clk); w++; end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic commit_model(input int x, input int y, input bit i4);
        for (int i = 0; i < 4; i++) begin
            top_mem[x][i] = i4 ? cm[i][3] : 2;
            left_mem[i]   = i4 ? cm[3][i] : 2;
        end
        top_av[x] = 1'b1;
        left_av   = 1'b1;
    endtask

    task automatic run_mb(input int x, input int y, input bit i4, input bit sl,
                          input int modes[16], input int stall_after);
        longint t0;
        start_mb(x, y, i4, sl);
        if (i4) begin
            for (int b = 0; b < 16; b++) begin
                send_blk(b, modes[b]);
                if (b == 0) t0 = acc_t;
                if (b == stall_after) begin
                    fork
                        begin
                            bus.out_ready = 1'b0;
                            repeat (5) begin
                                @(negedge clk);
                                chk("stall_blk_ready", int'(bus.blk_ready), 0);
                                chk("stall_out_valid", int'(bus.out_valid), 1);
                            end
                            @(posedge clk); #1;
                            bus.out_ready = 1'b1;
                        end
                    join_none
                end
            end
            chk("throughput_cycles", int'((acc_t - t0) / 10), (stall_after >= 0) ? 20 : 15);
        end
        @(negedge clk);
        chk("mb_done_pulse", int'(mb_done), 1);
        chk("busy_in_commit", int'(busy), 1);
        @(negedge clk);
        chk("mb_done_end", int'(mb_done), 0);
        chk("busy_after_commit", int'(busy), 0);
        commit_model(x, y, i4);
        drain();
    endtask

`ifdef INTRA_MODE_SLICE_EN
    localparam int RESTART_PRED = 2;
`else
    localparam int RESTART_PRED = 3;
`endif

    initial begin
        int md[16];
        bus.blk_valid = 1'b0;
        bus.blk_mode  = 4'd0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 128; i++) top_av[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mb_done", int'(mb_done), 0);
        chk("rst_out_pred", int'(bus.out_pred), 0);
        chk("rst_out_rem", int'(bus.out_rem), 0);
        chk("rst_blk_ready", int'(bus.blk_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        md = '{default: 0};
        run_mb(0, 0, 1'b1, 1'b1, md, -1);
        chk("mb00_b0_pred", res_pred[0], 2);
        chk("mb00_b0_flag", res_flag[0], 0);
        chk("mb00_b0_rem", res_rem[0], 0);
        chk("mb00_b1_pred", res_pred[1], 2);
        chk("mb00_b3_pred", res_pred[3], 0);
        chk("mb00_b3_flag", res_flag[3], 1);

        md = '{1,2,3,4,5,0,8,6,7,1,4,5,2,3,6,7};
        run_mb(1, 0, 1'b1, 1'b0, md, -1);
        md = '{0,1,2,4,5,3,6,3,7,8,0,1,2,3,4,3};
        run_mb(0, 1, 1'b1, 1'b0, md, -1);
        md = '{4,8,1,0,2,3,5,6,7,8,2,2,0,1,3,4};
        run_mb(1, 1, 1'b1, 1'b0, md, -1);
        chk("mb11_b0_pred", res_pred[0], 3);
        chk("mb11_b0_flag", res_flag[0], 0);
        chk("mb11_b0_rem", res_rem[0], 3);
        chk("mb11_b1_pred", res_pred[1], 4);
        chk("mb11_b1_rem", res_rem[1], 7);

        run_mb(2, 0, 1'b0, 1'b0, md, -1);
        md = '{2,1,0,3,4,5,6,7,8,2,2,2,1,1,0,0};
        run_mb(2, 1, 1'b1, 1'b0, md, -1);
        chk("mb21_b0_pred", res_pred[0], 2);
        chk("mb21_b0_flag", res_flag[0], 1);

        md = '{8,7,6,5,4,3,2,1,0,1,8,8,4,5,8,8};
        run_mb(3, 0, 1'b1, 1'b0, md, 3);

        // Abort an MB with the block counter at 7.
        start_mb(3, 1, 1'b1, 1'b0);
        for (int b = 0; b < 7; b++) send_blk(b, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_blk_ready", int'(bus.blk_ready), 0);
        exp_q.delete();
        left_av = 1'b0;
        for (int i = 0; i < 128; i++) top_av[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        md = '{1,3,5,7,0,2,4,6,8,1,2,3,4,5,6,7};
        run_mb(3, 1, 1'b1, 1'b0, md, -1);
        chk("restart_b0_pred", res_pred[0], RESTART_PRED);
        chk("restart_b0_rem", res_rem[0], 1);

`ifdef INTRA_MODE_SLICE_EN
        md = '{3,4,0,1,2,5,6,7,8,0,1,2,3,4,5,6};
        run_mb(5, 3, 1'b1, 1'b1, md, -1);
        chk("slice_b0_pred", res_pred[0], 2);
        chk("slice_b1_pred", res_pred[1], 2);
        md = '{2,2,3,3,4,4,5,5,6,6,7,7,8,8,0,0};
        run_mb(6, 3, 1'b1, 1'b0, md, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "time limit");
    end
endmodule
